// File: rtl/adc_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_rd_pkg
// Description : Shared types and constants for the ADC readout buffer.
//               Holds the readout state enum, the pixel index constants
//               and the settle counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_rd_pkg;

    // Settle counter width. Wide enough for SETTLE_CYC up to 15.
    localparam int c_CNT_W = 4;

    // Pixel order in the buffer and on the output stream
    localparam logic [1:0] c_PIX_R1C1 = 2'd0;
    localparam logic [1:0] c_PIX_R1C2 = 2'd1;
    localparam logic [1:0] c_PIX_R2C1 = 2'd2;
    localparam logic [1:0] c_PIX_R2C2 = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        SETTLE = 3'd2,
        HOLD   = 3'd3,
        END    = 3'd4,
        STREAM = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pix_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : pix_stream_out
// Description : 4-entry pixel buffer plus the valid/ready index sequencer.
//               Row captures write two entries at once; a start strobe
//               launches the stream at pixel 0 and o_done pulses with the
//               handshake of pixel 3.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_wr_en       - write one row (two columns) into the buffer
//               i_wr_row2     - 0: row 1 -> entries 0/1, 1: row 2 -> 2/3
//               i_col1/i_col2 - column samples to write
//               i_start       - begin streaming from pixel 0
//               i_ready       - consumer ready
//               o_data/o_idx  - current pixel value and index
//               o_valid       - o_data/o_idx valid
//               o_done        - pixel 3 accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pix_stream_out
    import adc_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_wr_row2,
    input  logic [DATA_W-1:0] i_col1,
    input  logic [DATA_W-1:0] i_col2,
    input  logic              i_start,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_idx,
    output logic              o_valid,
    output logic              o_done
);

    logic [DATA_W-1:0] r_buf [4];
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_idx;
    logic              r_valid;

    logic              w_xfer;
    logic              w_last;
    logic [1:0]        w_idx_nxt;

    assign w_xfer    = r_valid & i_ready;
    assign w_last    = (r_idx == c_PIX_R2C2);
    assign w_idx_nxt = r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_data  <= '0;
            r_idx   <= c_PIX_R1C1;
            r_valid <= 1'b0;
        end else begin
            if (i_wr_en) begin
                if (i_wr_row2) begin
                    r_buf[c_PIX_R2C1] <= i_col1;
                    r_buf[c_PIX_R2C2] <= i_col2;
                end else begin
                    r_buf[c_PIX_R1C1] <= i_col1;
                    r_buf[c_PIX_R1C2] <= i_col2;
                end
            end
            // Data is pre-fetched into r_data so the output is a plain
            // register, held unchanged while the consumer stalls.
            if (i_start) begin
                r_valid <= 1'b1;
                r_idx   <= c_PIX_R1C1;
                r_data  <= r_buf[c_PIX_R1C1];
            end else if (w_xfer) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_idx  <= w_idx_nxt;
                    r_data <= r_buf[w_idx_nxt];
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_idx   = r_idx;
    assign o_valid = r_valid;
    assign o_done  = w_xfer & w_last;

endmodule
`default_nettype wire

// File: rtl/adc_readout_buffer.sv
`default_nettype none
// ============================================================================
// Module      : adc_readout_buffer
// Description : Captures a 2x2 pixel frame during the ADC readout phase
//               (row enables NRE_1/NRE_2, active low, settle then sample)
//               and streams the 4 pixels over valid/ready once complete.
// Ports       : Clk, Reset           - clock, synchronous active-high reset
//               ADC                  - readout phase from exposure FSM
//               NRE_1, NRE_2         - row read enables, active low
//               Adc_Col1, Adc_Col2   - column converter outputs
//               Pix_Data, Pix_Idx    - streamed pixel and its index
//               Pix_Valid, Pix_Ready - stream handshake
//               Frame_Done           - pulse when pixel 3 is accepted
//               Frame_Err            - pulse when a phase ends incomplete
//               Overrun              - sticky, ADC rose while busy
// Revision    : 1.0 - initial release
// ============================================================================
module adc_readout_buffer
    import adc_rd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ADC,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic [DATA_W-1:0] Adc_Col1,
    input  logic [DATA_W-1:0] Adc_Col2,
    output logic [DATA_W-1:0] Pix_Data,
    output logic [1:0]        Pix_Idx,
    output logic              Pix_Valid,
    input  logic              Pix_Ready,
    output logic              Frame_Done,
    output logic              Frame_Err,
    output logic              Overrun
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_CYC - 1);

    state_t             r_state;
    logic               r_adc_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_row2;      // selected row: 0 = row 1, 1 = row 2
    logic [1:0]         r_cap;       // per-row captured flags
    logic               r_err;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_rise;
    logic               w_fall;
    logic               w_row1_lo;
    logic               w_row2_lo;
    logic               w_sel_lo;
    logic               w_sample;
    logic               w_start;
    logic               w_done;

    assign w_rise    = ADC & ~r_adc_d;
    assign w_fall    = ~ADC & r_adc_d;
    assign w_row1_lo = ~NRE_1;
    assign w_row2_lo = ~NRE_2;
    assign w_sel_lo  = r_row2 ? w_row2_lo : w_row1_lo;

    // A falling ADC edge pre-empts a sample landing in the same cycle.
    assign w_sample  = (r_state == SETTLE) && !w_fall && w_sel_lo && (r_cnt == c_CNT_LAST);
    assign w_start   = (r_state == END) && (r_cap == 2'b11) && !r_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_adc_d     <= 1'b0;
            r_cnt       <= '0;
            r_row2      <= 1'b0;
            r_cap       <= 2'b00;
            r_err       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_adc_d     <= ADC;
            r_frame_err <= 1'b0;

            // A new phase while busy is dropped; only IDLE accepts a rise.
            if (w_rise && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_cap   <= 2'b00;
                        r_err   <= 1'b0;
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (w_fall) begin
                        r_state <= END;
                    end else if (w_row1_lo && w_row2_lo) begin
                        r_err <= 1'b1;
                    end else if (w_row1_lo && !r_cap[0]) begin
                        r_row2  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end else if (w_row2_lo && !r_cap[1]) begin
                        r_row2  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_fall) begin
                        r_state <= END;
                    end else if (!w_sel_lo) begin
                        r_state <= ARMED;
                    end else if (w_sample) begin
                        r_cap[r_row2] <= 1'b1;
                        r_state       <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (w_fall) begin
                        r_state <= END;
                    end else if (!w_sel_lo) begin
                        r_state <= ARMED;
                    end
                end
                END: begin
                    if (w_start) begin
                        r_state <= STREAM;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                STREAM: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pix_stream_out #(
        .DATA_W (DATA_W)
    ) u_stream (
        .clk       (Clk),
        .rst       (Reset),
        .i_wr_en   (w_sample),
        .i_wr_row2 (r_row2),
        .i_col1    (Adc_Col1),
        .i_col2    (Adc_Col2),
        .i_start   (w_start),
        .i_ready   (Pix_Ready),
        .o_data    (Pix_Data),
        .o_idx     (Pix_Idx),
        .o_valid   (Pix_Valid),
        .o_done    (w_done)
    );

    assign Frame_Done = w_done;
    assign Frame_Err  = r_frame_err;
    assign Overrun    = r_overrun;

endmodule
`default_nettype wire
